flash_page_cache: RTL and testbench
===================================

# flash_page_cache

- Wishbone-slave SPI flash page cache in the user space.
- Holds one 2 KiB page (512 words) of an external single-bit SPI flash in internal storage.
- Exposes that page through an 8 MiB read window, plus four control registers.
- Pages are loaded either when software writes the page register (manual mode) or automatically when a read misses the cached page.

## Interface
- Parameters:
  - PAGE_WORDS, 512: words per cache page (page bytes = 4*PAGE_WORDS).
  - INIT_CMD, 8'hAB: wake-up command sent at enable.
- Ports (clock and reset first):
  - clk  in  1  system clock, rising-edge.
  - rst  in  1  reset; asynchronous, active-low.
  - wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone classic cycle, strobe and write enable.
  - wb_sel_i  in  4  byte lane selects.
  - wb_adr_i  in  24  byte address within the block.
  - wb_dat_i  in  32  write data.
  - wb_ack_o  out  1  single-cycle acknowledge.
  - wb_dat_o  out  32  read data.
  - flash_csb  out  1  chip select, active low.
  - flash_sck  out  1  SPI clock.
  - flash_mosi  out  1  serial data to the flash (io0).
  - flash_miso  in  1  serial data from the flash (io1).

## Operation
- Address map (wb_adr_i):
  - 0x00_0000–0x7F_FFFC: data window, read-only; writes are acked and ignored.
  - 0x80_0000: CONFIG. Bit0 = enable, bit1 = automatic page selection. Other bits read 0.
  - 0x80_0004: STATUS, read-only. Bit0 = initialised, bit1 = loading.
  - 0x80_0008: PAGE. Writing stores page number N; reads return the byte address N*4*PAGE_WORDS.
  - 0x80_000C: LOAD, read-only. Byte count (0..2048) already loaded into the cache for the current load.
- Register writes honour wb_sel_i byte lanes.
- Byte order: flash byte 4k lands in bits [7:0] of cache word k.
- States: DISABLED, INIT, IDLE, CMD, ADDR, DATA.
  - DISABLED:
    - entered at reset or when CONFIG.bit0 is cleared.
    - csb high; STATUS=0; any load is aborted and the cache is invalidated.
  - INIT: on enable, send INIT_CMD as one csb-low transaction, then raise csb and set initialised.
  - CMD/ADDR/DATA, a page load:
    - send read command 0x03, then a 24-bit byte address (page*2048), MSB first;
    - then receive 2048 bytes into the cache, with LOAD incrementing per byte;
    - raise csb at the end. loading=1 from load start to the last byte.
- Load triggers:
  - a write to PAGE: aborts any current load, clears LOAD and restarts. A write before initialisation is latched and starts when INIT finishes.
  - in automatic mode, a data read whose page (adr[22:11]) differs from the cached page, or with no valid page, sets PAGE to that page and starts a load.
- Data reads:
  - Manual mode: adr[10:2] indexes the cache; upper bits are ignored.
  - Any mode: ack is withheld until the word is present, i.e. word_index*4+4 <= LOAD, or the page is fully loaded.
  - Disabled: data reads ack immediately with 0.

## Timing
- Reset values: CONFIG=0, STATUS=0, PAGE=0, LOAD=0, wb_ack_o=0, wb_dat_o=0, flash_csb=1, flash_sck=0, flash_mosi=0.
- Register reads/writes: ack one cycle after stb, no wait states.
- SPI: sck runs at clk rate.
  - mosi changes on the sck falling edge; miso is sampled on the sck rising edge.
  - csb stays high at least 2 cycles between transactions.
- INIT completes within 12 cycles of the CONFIG write.
- A page load takes about 32 + 16384 cycles.
- Simultaneous PAGE write and byte completion: the write wins; LOAD restarts at 0.
- Clearing enable mid-load: csb rises next cycle.
- Reset mid-operation returns everything to reset values.

## Test plan
- Reset, then read STATUS and CONFIG -> both 0. Write CONFIG=1 -> STATUS reads 0 immediately, then 1 after the INIT transaction (0xAB on mosi).
- Write PAGE=0 -> STATUS=3. Read word 0 -> flash bytes 0–3. Read LOAD twice with a word read between -> value >0 and increasing. Read word 0x1FF -> stalls until done, then STATUS=1.
- Write PAGE=2 -> PAGE reads 0x1000, STATUS=3. Window words 0x00–0x03 and 0x10–0x13 -> flash words 0x400+n.
- Write CONFIG=3 while page 2 is loading -> STATUS=3, PAGE=0x1000. Read words 0x000–0x0F3 -> correct data, PAGE=0. Read word 0x400 -> PAGE=0x1000.
- Alternate reads of words 0x000 and 0x401 -> each miss reloads and correct data is returned. The last read, word 0x4F3, leaves PAGE=0x1000.
- Clear CONFIG mid-load -> csb high, STATUS=0. A data read then returns 0 immediately.

Source files
------------

// File: rtl/flash_page_cache_if.sv
// Wishbone classic slave bundle carrying host accesses into the flash page cache.
interface flash_page_cache_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [23:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        input  wb_ack_o, wb_dat_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        output wb_ack_o, wb_dat_o
    );
endinterface

// File: rtl/flash_page_cache.sv
// Caches one page of a single-bit SPI flash and serves it through a Wishbone read window,
// loading pages on a PAGE register write or, in automatic mode, on a read miss.
module flash_page_cache #(
    parameter int unsigned PAGE_WORDS = 512,
    parameter logic [7:0]  INIT_CMD   = 8'hAB
) (
    input  logic              clk,
    input  logic              rst,
    flash_page_cache_if.slave wb,
    output logic              flash_csb,
    output logic              flash_sck,
    output logic              flash_mosi,
    input  logic              flash_miso
);
    localparam int unsigned PAGE_BYTES = 4 * PAGE_WORDS;
    localparam int unsigned OFF_BITS   = $clog2(PAGE_BYTES);
    localparam int unsigned WORD_BITS  = OFF_BITS - 2;
    localparam int unsigned PAGE_BITS  = 23 - OFF_BITS;
    localparam int unsigned LOAD_BITS  = OFF_BITS + 1;
    localparam logic [7:0]  READ_CMD   = 8'h03;

    typedef enum logic [2:0] {DISABLED, INIT, IDLE, CMD, ADDR, DATA} state_t;

    state_t                 state_q, state_d;
    logic [4:0]             bitCnt_q;
    logic [1:0]             gap_q;
    logic                   cfgEnable_q, cfgEnable_d;
    logic                   cfgAuto_q, cfgAuto_d;
    logic                   initDone_q;
    logic                   pending_q;
    logic                   pageValid_q;
    logic [PAGE_BITS-1:0]   page_q;
    logic [LOAD_BITS-1:0]   loadCnt_q;
    logic [6:0]             shift_q;
    logic                   misoSample_q;
    logic                   ack_q;
    logic [31:0]            rdata_q;
    logic [31:0]            cache_q [PAGE_WORDS];

    logic                   req, isReg, regWrite, dataRead;
    logic                   cfgWrite, pageWrite, autoMiss, restart;
    logic                   byteDone, lastByte, wordReady, loading, sckEn;
    logic [1:0]             regSel;
    logic [PAGE_BITS-1:0]   adrPage;
    logic [WORD_BITS-1:0]   wordIdx;
    logic [23:0]            flashAddr;
    logic [31:0]            cfgMerged, pageMerged, regRead;
    logic                   unusedBits;

    function automatic logic [31:0] mergeLanes(input logic [31:0] oldVal,
                                               input logic [31:0] newVal,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = sel[i] ? newVal[8*i +: 8] : oldVal[8*i +: 8];
        return r;
    endfunction

    assign req       = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    assign isReg     = wb.wb_adr_i[23];
    assign regSel    = wb.wb_adr_i[3:2];
    assign regWrite  = req & isReg & wb.wb_we_i;
    assign dataRead  = req & ~isReg & ~wb.wb_we_i;
    assign adrPage   = wb.wb_adr_i[22:OFF_BITS];
    assign wordIdx   = wb.wb_adr_i[OFF_BITS-1:2];
    assign flashAddr = {1'b0, page_q, {OFF_BITS{1'b0}}};

    assign cfgMerged  = mergeLanes({30'd0, cfgAuto_q, cfgEnable_q}, wb.wb_dat_i, wb.wb_sel_i);
    assign pageMerged = mergeLanes(32'(page_q), wb.wb_dat_i, wb.wb_sel_i);
    assign cfgWrite   = regWrite & (regSel == 2'd0);
    assign pageWrite  = regWrite & (regSel == 2'd2);
    assign cfgEnable_d = cfgWrite ? cfgMerged[0] : cfgEnable_q;
    assign cfgAuto_d   = cfgWrite ? cfgMerged[1] : cfgAuto_q;

    // A miss only counts once enabled; the page switch then makes the same read a hit.
    assign autoMiss  = dataRead & cfgEnable_q & cfgAuto_q & (~pageValid_q | (adrPage != page_q));
    assign restart   = pageWrite | autoMiss;
    assign byteDone  = (state_q == DATA) && (bitCnt_q[2:0] == 3'd7);
    assign lastByte  = byteDone && (loadCnt_q == LOAD_BITS'(PAGE_BYTES - 1));
    assign wordReady = (LOAD_BITS'({wordIdx, 2'b00}) + LOAD_BITS'(4)) <= loadCnt_q;
    assign loading   = cfgEnable_q & (pending_q | (state_q == CMD) | (state_q == ADDR) | (state_q == DATA));
    assign unusedBits = ^{wb.wb_adr_i[1:0], cfgMerged[31:2], pageMerged[31:PAGE_BITS]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= DISABLED;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DISABLED: if (cfgEnable_q) state_d = INIT;
            INIT:     if (bitCnt_q == 5'd7) state_d = IDLE;
            IDLE:     if (pending_q && gap_q == 2'd0 && !restart) state_d = CMD;
            CMD:      if (restart) state_d = IDLE;
                      else if (bitCnt_q == 5'd7) state_d = ADDR;
            ADDR:     if (restart) state_d = IDLE;
                      else if (bitCnt_q == 5'd23) state_d = DATA;
            DATA:     if (restart || lastByte) state_d = IDLE;
            default:  state_d = DISABLED;
        endcase
        if (!cfgEnable_d) state_d = DISABLED;
    end

    always_comb begin
        flash_csb  = 1'b1;
        flash_mosi = 1'b0;
        sckEn      = 1'b0;
        case (state_q)
            INIT: begin
                flash_csb  = 1'b0;
                sckEn      = 1'b1;
                flash_mosi = INIT_CMD[3'd7 - bitCnt_q[2:0]];
            end
            CMD: begin
                flash_csb  = 1'b0;
                sckEn      = 1'b1;
                flash_mosi = READ_CMD[3'd7 - bitCnt_q[2:0]];
            end
            ADDR: begin
                flash_csb  = 1'b0;
                sckEn      = 1'b1;
                flash_mosi = flashAddr[5'd23 - bitCnt_q];
            end
            DATA: begin
                flash_csb = 1'b0;
                sckEn     = 1'b1;
            end
            default: ;
        endcase
    end

    // sck is high during the low half of clk, so mosi (moved at posedge clk) shifts on sck falling.
    assign flash_sck = sckEn & ~clk;

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) misoSample_q <= 1'b0;
        else      misoSample_q <= flash_miso;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bitCnt_q    <= 5'd0;
            gap_q       <= 2'd0;
            cfgEnable_q <= 1'b0;
            cfgAuto_q   <= 1'b0;
            initDone_q  <= 1'b0;
            pending_q   <= 1'b0;
            pageValid_q <= 1'b0;
            page_q      <= '0;
            loadCnt_q   <= '0;
            shift_q     <= 7'd0;
        end else begin
            bitCnt_q    <= (state_d != state_q) ? 5'd0 : bitCnt_q + 5'd1;
            cfgEnable_q <= cfgEnable_d;
            cfgAuto_q   <= cfgAuto_d;
            if (state_q == IDLE && gap_q != 2'd0) gap_q <= gap_q - 2'd1;
            if (state_d == IDLE && state_q != IDLE) gap_q <= 2'd2;
            if (state_q == INIT && state_d == IDLE) initDone_q <= 1'b1;
            if (state_q == DATA) shift_q <= {shift_q[5:0], misoSample_q};
            if (byteDone) loadCnt_q <= loadCnt_q + LOAD_BITS'(1);
            if (state_q == IDLE && state_d == CMD) pending_q <= 1'b0;
            // A restart outranks a byte landing in the same cycle.
            if (restart) begin
                page_q      <= pageWrite ? pageMerged[PAGE_BITS-1:0] : adrPage;
                pending_q   <= 1'b1;
                pageValid_q <= 1'b1;
                loadCnt_q   <= '0;
            end
            if (!cfgEnable_d) begin
                initDone_q  <= 1'b0;
                pageValid_q <= 1'b0;
                loadCnt_q   <= '0;
                if (cfgEnable_q) pending_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (byteDone)
            cache_q[loadCnt_q[OFF_BITS-1:2]][8*loadCnt_q[1:0] +: 8] <= {shift_q, misoSample_q};
    end

    always_comb begin
        regRead = 32'd0;
        case (regSel)
            2'd0: regRead = {30'd0, cfgAuto_q, cfgEnable_q};
            2'd1: regRead = {30'd0, loading, initDone_q};
            2'd2: regRead = 32'(flashAddr);
            2'd3: regRead = 32'(loadCnt_q);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            ack_q <= 1'b0;
            if (req) begin
                if (isReg || wb.wb_we_i) begin
                    ack_q <= 1'b1;
                    if (!wb.wb_we_i) rdata_q <= regRead;
                end else if (!cfgEnable_q) begin
                    ack_q   <= 1'b1;
                    rdata_q <= 32'd0;
                end else if (!autoMiss && wordReady) begin
                    ack_q   <= 1'b1;
                    rdata_q <= cache_q[wordIdx];
                end
            end
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = rdata_q;
endmodule

// File: tb/tb_flash_page_cache.sv
// Directed bench for flash_page_cache with a behavioural SPI read-only flash model.
module tb_flash_page_cache;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flash_csb, flash_sck, flash_mosi;
    logic flash_miso = 1'b0;

    always #5 clk = ~clk;

    flash_page_cache_if bus();

    flash_page_cache dut (
        .clk       (clk),
        .rst       (rst),
        .wb        (bus.slave),
        .flash_csb (flash_csb),
        .flash_sck (flash_sck),
        .flash_mosi(flash_mosi),
        .flash_miso(flash_miso)
    );

    int checkCount = 0;
    int errorCount = 0;

    // Flash contents: a fixed scramble of the byte address.
    function automatic logic [7:0] flashByte(input logic [23:0] a);
        return a[7:0] ^ {a[12:8], a[15:13]} ^ 8'h5A;
    endfunction

    function automatic logic [31:0] expWord(input logic [23:0] a);
        return {flashByte(a + 24'd3), flashByte(a + 24'd2), flashByte(a + 24'd1), flashByte(a)};
    endfunction

    int          bitsIn = 0;
    int          dIdx;
    logic [7:0]  cmdIn = 8'd0;
    logic [7:0]  lastCmd = 8'd0;
    logic [23:0] addrIn = 24'd0;
    logic [7:0]  dByte;

    always @(negedge flash_csb) bitsIn = 0;

    always @(posedge flash_sck) begin
        if (!flash_csb) begin
            if (bitsIn < 8) cmdIn = {cmdIn[6:0], flash_mosi};
            else if (bitsIn < 32) addrIn = {addrIn[22:0], flash_mosi};
            bitsIn++;
            if (bitsIn == 8) lastCmd = cmdIn;
        end
    end

    always @(negedge flash_sck) begin
        if (!flash_csb && bitsIn >= 32 && cmdIn == 8'h03) begin
            dIdx       = bitsIn - 32;
            dByte      = flashByte(addrIn + 24'(dIdx / 8));
            flash_miso = dByte[7 - (dIdx % 8)];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [23:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        int n;
        @(posedge clk); #1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b1;
        bus.wb_sel_i = sel;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.wb_ack_o && n < 50);
        checkOutput("write_ack", 32'(bus.wb_ack_o), 32'd1);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic readBus(input logic [23:0] adr, output logic [31:0] data, output int cycles);
        @(posedge clk); #1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_sel_i = 4'hF;
        bus.wb_adr_i = adr;
        cycles = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
        end while (!bus.wb_ack_o && cycles < 20000);
        checkOutput("read_ack", 32'(bus.wb_ack_o), 32'd1);
        data = bus.wb_dat_o;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
    endtask

    task automatic checkRead(input string tag, input logic [23:0] adr, input logic [31:0] expected);
        logic [31:0] d;
        int c;
        readBus(adr, d, c);
        checkOutput(tag, d, expected);
    endtask

    localparam logic [23:0] CONFIG = 24'h80_0000;
    localparam logic [23:0] STATUS = 24'h80_0004;
    localparam logic [23:0] PAGE   = 24'h80_0008;
    localparam logic [23:0] LOAD   = 24'h80_000C;

    initial begin
        logic [31:0] d, l1, l2;
        int c;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_sel_i = 4'h0;
        bus.wb_adr_i = 24'd0;
        bus.wb_dat_i = 32'd0;

        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_csb", 32'(flash_csb), 32'd1);
        checkOutput("rst_sck", 32'(flash_sck), 32'd0);
        checkOutput("rst_mosi", 32'(flash_mosi), 32'd0);
        checkOutput("rst_ack", 32'(bus.wb_ack_o), 32'd0);
        checkOutput("rst_dat", bus.wb_dat_o, 32'd0);
        @(negedge clk) rst = 1'b1;

        readBus(STATUS, d, c);
        checkOutput("status_reset", d, 32'd0);
        checkOutput("reg_latency", 32'(c), 32'd1);
        checkRead("config_reset", CONFIG, 32'd0);
        checkRead("page_reset", PAGE, 32'd0);
        checkRead("load_reset", LOAD, 32'd0);

        $display("[TB] enable and INIT");
        applyStimulus(CONFIG, 32'd1, 4'hF);
        checkRead("status_during_init", STATUS, 32'd0);
        repeat (14) @(posedge clk);
        checkRead("status_after_init", STATUS, 32'd1);
        checkOutput("init_cmd", 32'(lastCmd), 32'h0000_00AB);

        $display("[TB] manual load of page 0");
        applyStimulus(PAGE, 32'd0, 4'hF);
        checkRead("status_loading", STATUS, 32'd3);
        checkRead("p0_word0", 24'h000000, expWord(24'h000000));
        readBus(LOAD, l1, c);
        checkOutput("load_nonzero", 32'(l1 != 32'd0), 32'd1);
        checkRead("p0_word10", 24'h000040, expWord(24'h000040));
        readBus(LOAD, l2, c);
        checkOutput("load_increasing", 32'(l2 > l1), 32'd1);
        checkOutput("read_cmd", 32'(lastCmd), 32'h0000_0003);
        checkRead("p0_word1ff", 24'h0007FC, expWord(24'h0007FC));
        checkRead("status_loaded", STATUS, 32'd1);
        checkRead("load_full", LOAD, 32'd2048);

        $display("[TB] manual load of page 2");
        applyStimulus(PAGE, 32'd2, 4'hF);
        checkRead("page2_addr", PAGE, 32'h0000_1000);
        checkRead("status_p2", STATUS, 32'd3);
        for (int n = 0; n < 4; n++) begin
            checkRead("p2_win_lo", 24'(4 * n), expWord(24'h001000 + 24'(4 * n)));
            checkRead("p2_win_hi", 24'(4 * (n + 16)), expWord(24'h001000 + 24'(4 * (n + 16))));
        end

        $display("[TB] automatic mode");
        applyStimulus(CONFIG, 32'd3, 4'hF);
        checkRead("status_auto", STATUS, 32'd3);
        checkRead("page_auto", PAGE, 32'h0000_1000);
        checkRead("auto_w000", 24'h000000, expWord(24'h000000));
        checkRead("auto_w0f3", 24'h0003CC, expWord(24'h0003CC));
        checkRead("page_after_p0", PAGE, 32'd0);
        checkRead("auto_w400", 24'h001000, expWord(24'h001000));
        checkRead("page_after_p2", PAGE, 32'h0000_1000);
        for (int i = 0; i < 2; i++) begin
            checkRead("alt_w000", 24'h000000, expWord(24'h000000));
            checkRead("alt_w401", 24'h001004, expWord(24'h001004));
        end
        checkRead("auto_w4f3", 24'h0013CC, expWord(24'h0013CC));
        checkRead("page_final", PAGE, 32'h0000_1000);

        $display("[TB] byte-lane write to PAGE");
        applyStimulus(PAGE, 32'h0000_0F05, 4'b0010);
        checkRead("page_sel", PAGE, 32'h0078_1000);

        $display("[TB] disable mid-load");
        repeat (200) @(posedge clk);
        applyStimulus(CONFIG, 32'd0, 4'b0001);
        checkOutput("disable_csb", 32'(flash_csb), 32'd1);
        checkRead("status_disabled", STATUS, 32'd0);
        checkRead("load_disabled", LOAD, 32'd0);
        readBus(24'h000000, d, c);
        checkOutput("disabled_data", d, 32'd0);
        checkOutput("disabled_latency", 32'(c), 32'd1);

        $display("[TB] reset mid-operation");
        applyStimulus(CONFIG, 32'd1, 4'hF);
        applyStimulus(PAGE, 32'd1, 4'hF);
        repeat (100) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        checkOutput("midrst_csb", 32'(flash_csb), 32'd1);
        checkOutput("midrst_ack", 32'(bus.wb_ack_o), 32'd0);
        @(negedge clk) rst = 1'b1;
        checkRead("midrst_config", CONFIG, 32'd0);
        checkRead("midrst_page", PAGE, 32'd0);
        checkRead("midrst_status", STATUS, 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule
